alu4_sched: RTL and testbench

Request scheduler that shares the 4-lane ALU (`Top_Module_4_ALU`) between several requesters. It arbitrates round-robin among requesters presenting a 4-bit operation and two 64-bit packed operand vectors. It registers the granted operation onto the ALU inputs and waits a fixed settle latency. It then returns the 64-bit result with per-lane exception, overflow and underflow flags through a valid/ready response port. It sits between the wishbone/logic-analyzer front end and the ALU inside `user_project_wrapper`.

---
 rtl/alu4_sched_pkg.sv | 27 ++
 rtl/alu4_sched_rr_arbiter.sv | 42 ++++
 rtl/alu4_sched.sv | 186 ++++++++++++++++++
 tb/tb_alu4_sched.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_sched_pkg.sv
// alu4_sched_pkg -- shared constants, FSM state type and a flag helper for
// the ALU request scheduler.
//
// Contents:
//   LANES, LANE_W, OP_W, DATA_W : ALU geometry (4 lanes x 16 bits, 4-bit op)
//   state_e                     : scheduler FSM state {IDLE, WAIT, RESP}
//   any_flag()                  : OR-reduce the per-lane exception flags
package alu4_sched_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int OP_W   = 4;
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic any_flag(input logic [LANES-1:0] exc,
                                    input logic [LANES-1:0] ovf,
                                    input logic [LANES-1:0] unf);
    return |{exc, ovf, unf};
  endfunction

endpackage

// File: rtl/alu4_sched_rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin arbiter.
//
// Grants the first asserted request found searching upward from ptr_i with
// wrap-around.
//
// Ports:
//   req_i       in  N   request vector
//   ptr_i       in  IW  search start index (highest priority this cycle)
//   grant_o     out N   one-hot grant, all zero when no request
//   grant_idx_o out IW  index of the granted request (0 when none)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic found;
  int   s;

  always_comb begin
    // NOTE: every output and temporary gets a default before the search
    // loop, so no path leaves a value unassigned and no latch is inferred.
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    s           = 0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr_i) + i;
      if (s >= N) s = s - N;
      if (!found && req_i[s[IW-1:0]]) begin
        found              = 1'b1;
        grant_o[s[IW-1:0]] = 1'b1;
        grant_idx_o        = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu4_sched.sv
// alu4_sched -- shares one combinational 4-lane ALU between NUM_REQ
// requesters. A round-robin arbiter picks a requester in IDLE, its operation
// is registered onto the ALU inputs, the result is sampled ALU_LAT cycles
// later and returned through a valid/ready response port.
//
// Parameters: NUM_REQ (2..8) requesters, ALU_LAT (1..15) settle cycles.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   req_valid/req_ready         per-requester request handshake
//   req_op/req_a/req_b          packed per-requester op and operands
//   rsp_valid/rsp_ready         response handshake
//   rsp_id, rsp_result          requester index and sampled ALU result
//   rsp_exc/ovf/unf, rsp_err    sampled per-lane flags and their OR
//   busy                        FSM not in IDLE
//   alu_op/alu_a/alu_b          registered ALU inputs
//   alu_result, alu_exc/ovf/unf ALU outputs
// Optional (macro ALU4_SCHED_STATS_EN): stat_ops, stat_err saturating
// 32-bit counters of response handshakes and erroneous responses.
module alu4_sched
  import alu4_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ALU_LAT = 1,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IW-1:0]             rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [LANES-1:0]          rsp_exc,
  output logic [LANES-1:0]          rsp_ovf,
  output logic [LANES-1:0]          rsp_unf,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic [LANES-1:0]          alu_exc,
  input  logic [LANES-1:0]          alu_ovf,
  input  logic [LANES-1:0]          alu_unf
`ifdef ALU4_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_ops,
  output logic [31:0]               stat_err
`endif
);

  localparam int CW = 4;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                handshake;

  logic                rsp_valid_q;
  logic [IW-1:0]       rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;
  logic [LANES-1:0]    rsp_exc_q, rsp_ovf_q, rsp_unf_q;
  logic [OP_W-1:0]     alu_op_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // The arbiter only grants valid requesters, so any ready bit seen with its
  // valid is the accepted request.
  assign handshake = |(req_valid & req_ready);

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake)         state_d = WAIT;
      WAIT:    if (cnt_q == CW'(1))   state_d = RESP;
      RESP:    if (rsp_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output decode: grants are offered only while idle.
  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    if (state_q == IDLE) begin
      req_ready = grant;
      busy      = 1'b0;
    end
  end

  // Datapath: operand capture, latency count, result sampling.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_exc_q    <= '0;
      rsp_ovf_q    <= '0;
      rsp_unf_q    <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (handshake) begin
          alu_op_q <= req_op[grant_idx*OP_W +: OP_W];
          alu_a_q  <= req_a[grant_idx*DATA_W +: DATA_W];
          alu_b_q  <= req_b[grant_idx*DATA_W +: DATA_W];
          rsp_id_q <= grant_idx;
          rr_ptr_q <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          cnt_q    <= CW'(ALU_LAT);
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            rsp_result_q <= alu_result;
            rsp_exc_q    <= alu_exc;
            rsp_ovf_q    <= alu_ovf;
            rsp_unf_q    <= alu_unf;
            rsp_valid_q  <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_exc    = rsp_exc_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_unf    = rsp_unf_q;
  assign rsp_err    = any_flag(rsp_exc_q, rsp_ovf_q, rsp_unf_q);
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

`ifdef ALU4_SCHED_STATS_EN
  logic        rsp_hs;
  logic [31:0] stat_ops_q, stat_err_q;

  assign rsp_hs = rsp_valid_q & rsp_ready;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stat_ops_q <= '0;
      stat_err_q <= '0;
    end else if (rsp_hs) begin
      if (stat_ops_q != '1)            stat_ops_q <= stat_ops_q + 1'b1;
      if (rsp_err && stat_err_q != '1) stat_err_q <= stat_err_q + 1'b1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_err = stat_err_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_alu4_sched.sv
// tb_alu4_sched -- scoreboard bench for alu4_sched. Stimulus pushes the
// expected response for every accepted request; a monitor pops and compares
// on each response handshake. A second instance with ALU_LAT=3 covers the
// latency sweep. Stats counters are checked when ALU4_SCHED_STATS_EN is set.
module tb_alu4_sched;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_rsp = 0;

  // Main instance (ALU_LAT=1)
  logic [3:0]   req_valid, req_ready;
  logic [15:0]  req_op;
  logic [255:0] req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]   rsp_exc, rsp_ovf, rsp_unf, alu_op;
  logic [3:0]   flag_exc, flag_ovf, flag_unf;
`ifdef ALU4_SCHED_STATS_EN
  logic [31:0]  stat_ops, stat_err;
`endif

  // Latency-sweep instance (ALU_LAT=3)
  logic [3:0]   req_valid3, req_ready3;
  logic [15:0]  req_op3;
  logic [255:0] req_a3, req_b3;
  logic         rsp_valid3, rsp_ready3, rsp_err3, busy3;
  logic [1:0]   rsp_id3;
  logic [63:0]  rsp_result3, alu_a3, alu_b3, alu_result3;
  logic [3:0]   rsp_exc3, rsp_ovf3, rsp_unf3, alu_op3;
  logic [3:0]   zero_flags = 4'h0;
`ifdef ALU4_SCHED_STATS_EN
  logic [31:0]  stat_ops3, stat_err3;
`endif

  typedef struct {
    int          id;
    logic [63:0] res;
    logic [3:0]  exc, ovf, unf;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Stand-in ALU: op 1 lane add, op 2 lane subtract, otherwise XOR.
  function automatic logic [63:0] alu_model(input logic [3:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) begin
      case (op)
        4'h1:    r[16*l +: 16] = a[16*l +: 16] + b[16*l +: 16];
        4'h2:    r[16*l +: 16] = a[16*l +: 16] - b[16*l +: 16];
        default: r[16*l +: 16] = a[16*l +: 16] ^ b[16*l +: 16];
      endcase
    end
    return r;
  endfunction

  assign alu_result  = alu_model(alu_op, alu_a, alu_b);
  assign alu_result3 = alu_model(alu_op3, alu_a3, alu_b3);

  alu4_sched #(.NUM_REQ(4), .ALU_LAT(1)) u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_exc(rsp_exc), .rsp_ovf(rsp_ovf),
    .rsp_unf(rsp_unf), .rsp_err(rsp_err), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_exc(flag_exc), .alu_ovf(flag_ovf),
`ifdef ALU4_SCHED_STATS_EN
    .stat_ops(stat_ops), .stat_err(stat_err),
`endif
    .alu_unf(flag_unf)
  );

  alu4_sched #(.NUM_REQ(4), .ALU_LAT(3)) u_dut3 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .rsp_exc(rsp_exc3), .rsp_ovf(rsp_ovf3),
    .rsp_unf(rsp_unf3), .rsp_err(rsp_err3), .busy(busy3),
    .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_result(alu_result3), .alu_exc(zero_flags), .alu_ovf(zero_flags),
`ifdef ALU4_SCHED_STATS_EN
    .stat_ops(stat_ops3), .stat_err(stat_err3),
`endif
    .alu_unf(zero_flags)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every response handshake against the scoreboard head.
  always @(negedge wb_clk_i) begin : mon
    exp_t e;
    if (!wb_rst_i && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_result", rsp_result, e.res);
        check("rsp_exc", 64'(rsp_exc), 64'(e.exc));
        check("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
        check("rsp_unf", 64'(rsp_unf), 64'(e.unf));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
      n_rsp++;
    end
  end

  // Offer one request, push its expectation, return just after the
  // accepting edge with the valid dropped.
  task automatic do_req(input int id, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input bit push);
    bit got = 1'b0;
    @(posedge wb_clk_i); #1;
    req_op[4*id +: 4]  = op;
    req_a[64*id +: 64] = a;
    req_b[64*id +: 64] = b;
    req_valid[id]      = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge wb_clk_i);
      if (req_ready[id]) got = 1'b1;
    end
    check("grant_wait", 64'(got), 1);
    if (got) begin
      if (push)
        sb.push_back('{id: id, res: exp_res, exc: flag_exc, ovf: flag_ovf,
                       unf: flag_unf, err: |{flag_exc, flag_ovf, flag_unf}});
      @(posedge wb_clk_i); #1;
      check("alu_op_cap", 64'(alu_op), 64'(op));
      check("alu_a_cap", alu_a, a);
      check("alu_b_cap", alu_b, b);
    end
    req_valid[id] = 1'b0;
  endtask

  // Count edges from the accepting edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    bit leak = 1'b0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge wb_clk_i); #1;
      lat++;
      if (rsp_valid) break;
      if (req_ready != 0) leak = 1'b1;
    end
    check("ready_in_wait", 64'(leak), 0);
    check("ready_in_resp", 64'(req_ready), 0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge wb_clk_i);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    check("drain", 64'(done), 1);
  endtask

  logic [63:0] fair_a   [4] = '{64'h1000_2000_3000_4000, 64'h1000_2000_3000_4001,
                                64'h1000_2000_3000_4002, 64'h1000_2000_3000_4003};
  logic [63:0] fair_exp [4] = '{64'h1001_2001_3001_4001, 64'h1001_2001_3001_4002,
                                64'h1001_2001_3001_4003, 64'h1001_2001_3001_4004};

  initial begin
    int lat, prev, gi;
    bit got, bad;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    req_valid3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;
    flag_exc = '0; flag_ovf = '0; flag_unf = '0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    prev = 0;
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_id", 64'(rsp_id), 0);
    check("rst_rsp_valid3", 64'(rsp_valid3), 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Fairness: all requesters valid continuously.
    @(posedge wb_clk_i); #1;
    for (int i = 0; i < 4; i++) begin
      req_op[4*i +: 4]  = 4'h1;
      req_a[64*i +: 64] = fair_a[i];
      req_b[64*i +: 64] = 64'h0001_0001_0001_0001;
    end
    req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge wb_clk_i);
        if (req_ready != 0) got = 1'b1;
      end
      check("fair_grant_seen", 64'(got), 1);
      if (!got) break;
      gi = -1;
      for (int j = 0; j < 4; j++) if (req_ready[j]) gi = j;
      check("fair_onehot", 64'($countones(req_ready)), 1);
      check("fair_order", 64'(gi), 64'(g % 4));
      if (g > 0) check("fair_period", 64'(cyc - prev), 3);
      prev = cyc;
      if (gi >= 0)
        sb.push_back('{id: gi, res: fair_exp[gi], exc: 4'h0, ovf: 4'h0,
                       unf: 4'h0, err: 1'b0});
      @(posedge wb_clk_i);
    end
    #1 req_valid = '0;
    drain();

    // Single op from requester 2, hand-computed lane sums.
    do_req(2, 4'h1, 64'h3C00_4000_4200_4400, 64'h3C00_3C00_3C00_3C00,
           64'h7800_7C00_7E00_8000, 1'b1);
    wait_rsp(lat);
    check("single_latency", 64'(lat), 1);
    @(posedge wb_clk_i); #1;
    check("single_rsp_one_cycle", 64'(rsp_valid), 0);
    check("single_idle_after", 64'(busy), 0);
    drain();

    // Back-pressure: stall 10 cycles in RESP with another request pending.
    rsp_ready = 1'b0;
    do_req(1, 4'h2, 64'h0005_0010_0100_1000, 64'h0001_0001_0001_0001,
           64'h0004_000F_00FF_0FFF, 1'b1);
    wait_rsp(lat);
    check("bp_latency", 64'(lat), 1);
    req_op[3:0] = 4'h1; req_a[63:0] = 64'h1; req_b[63:0] = 64'h1;
    req_valid[0] = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge wb_clk_i); #1;
      if (!rsp_valid || rsp_result !== 64'h0004_000F_00FF_0FFF ||
          rsp_id !== 2'd1 || req_ready != 0) bad = 1'b1;
    end
    check("bp_stable", 64'(bad), 0);
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    @(posedge wb_clk_i); #1;
    check("bp_release_valid", 64'(rsp_valid), 0);
    check("bp_release_idle", 64'(busy), 0);
    drain();

    // Flags pass through and drive rsp_err.
    flag_ovf = 4'b0100;
    do_req(3, 4'h3, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
           64'hF0F0_0F0F_F0F0_0F0F, 1'b1);
    drain();
    flag_ovf = 4'b0000; flag_exc = 4'b0001; flag_unf = 4'b1000;
    do_req(0, 4'h1, 64'h0, 64'h0, 64'h0, 1'b1);
    drain();
    flag_exc = '0; flag_unf = '0;
`ifdef ALU4_SCHED_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'(n_rsp));
    check("stat_err", 64'(stat_err), 2);
`endif

    // Reset mid-operation: in-flight op is dropped, pointer returns to 0.
    do_req(2, 4'h1, 64'h1, 64'h1, 64'h2, 1'b0);
    check("rst_mid_busy_before", 64'(busy), 1);
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_rsp_valid", 64'(rsp_valid), 0);
    check("rst_mid_busy", 64'(busy), 0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    req_op[3:0] = 4'h1;   req_a[63:0] = 64'h5;    req_b[63:0] = 64'h6;
    req_op[15:12] = 4'h1; req_a[255:192] = 64'h7; req_b[255:192] = 64'h8;
    req_valid = 4'b1001;
    @(negedge wb_clk_i);
    check("rst_mid_first_grant", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    do_req(0, 4'h1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0006,
           64'h0000_0000_0000_000B, 1'b1);
    drain();
    check("sb_empty", 64'(sb.size()), 0);

    // Latency sweep on the ALU_LAT=3 instance.
    @(posedge wb_clk_i); #1;
    req_op3[7:4]    = 4'h2;
    req_a3[127:64]  = 64'h0010_0020_0030_0040;
    req_b3[127:64]  = 64'h0001_0002_0003_0004;
    req_valid3[1]   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge wb_clk_i);
      if (req_ready3[1]) got = 1'b1;
    end
    check("lat3_grant", 64'(got), 1);
    @(posedge wb_clk_i); #1;
    req_valid3 = '0;
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge wb_clk_i); #1;
      lat++;
      if (rsp_valid3) break;
    end
    check("lat3_latency", 64'(lat), 3);
    check("lat3_result", rsp_result3, 64'h000F_001E_002D_003C);
    check("lat3_id", 64'(rsp_id3), 1);
    check("lat3_err", 64'(rsp_err3), 0);
    @(posedge wb_clk_i); #1;
    check("lat3_one_cycle", 64'(rsp_valid3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
